// File: rtl/decode_pipe.sv
// Instruction decode stage: field split, immediate extension, register file with
// write-through read bypass, load-use hazard detection and the ID/EX pipeline register.
module decode_pipe #(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned REGNUM           = 8,
    parameter int unsigned ADDRESSWIDTH     = 3,
    parameter int unsigned OPCODEWIDTH      = 4,
    parameter int unsigned INSTRUCTIONWIDTH = 24,
    parameter int unsigned FIELDWIDTH       = 4,
    parameter bit          IMM_SIGNED       = 1'b0,
    parameter bit          ZERO_REG         = 1'b0,
    parameter logic [OPCODEWIDTH-1:0] LOAD_OPCODE = OPCODEWIDTH'(4'b0011),
    parameter int unsigned CNTWIDTH         = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inValid,
    input  logic [INSTRUCTIONWIDTH-1:0] instruction,
    input  logic [WIDTH-1:0]            PC,
    input  logic                        writeE,
    input  logic [ADDRESSWIDTH-1:0]     writeA,
    input  logic [WIDTH-1:0]            dataToSave,
    input  logic                        flush,
    input  logic                        stallIn,
    output logic                        outValid,
    output logic [OPCODEWIDTH-1:0]      opcode,
    output logic [ADDRESSWIDTH-1:0]     regDestinationAddress,
    output logic [ADDRESSWIDTH-1:0]     r1A,
    output logic [ADDRESSWIDTH-1:0]     r2A,
    output logic [WIDTH-1:0]            rd1D,
    output logic [WIDTH-1:0]            rd2D,
    output logic [WIDTH-1:0]            inmediate,
    output logic [WIDTH-1:0]            pcOut,
    output logic                        stallOut,
    output logic [CNTWIDTH-1:0]         hazardCount
);

    localparam int unsigned OP_LSB   = INSTRUCTIONWIDTH - OPCODEWIDTH;
    localparam int unsigned RD_LSB   = OP_LSB - FIELDWIDTH;
    localparam int unsigned RS1_LSB  = RD_LSB - FIELDWIDTH;
    localparam int unsigned RS2_LSB  = RS1_LSB - FIELDWIDTH;
    localparam int unsigned IMMWIDTH = RS2_LSB;

    // Field extraction; only the low address bits of each register field are meaningful
    logic [OPCODEWIDTH-1:0]  dec_op;
    logic [FIELDWIDTH-1:0]   rd_field;
    logic [FIELDWIDTH-1:0]   rs1_field;
    logic [FIELDWIDTH-1:0]   rs2_field;
    logic [ADDRESSWIDTH-1:0] dec_rd;
    logic [ADDRESSWIDTH-1:0] dec_rs1;
    logic [ADDRESSWIDTH-1:0] dec_rs2;
    logic [IMMWIDTH-1:0]     dec_imm_raw;
    logic [WIDTH-1:0]        dec_imm;
    logic                    unused_fields;

    assign dec_op      = instruction[OP_LSB +: OPCODEWIDTH];
    assign rd_field    = instruction[RD_LSB +: FIELDWIDTH];
    assign rs1_field   = instruction[RS1_LSB +: FIELDWIDTH];
    assign rs2_field   = instruction[RS2_LSB +: FIELDWIDTH];
    assign dec_rd      = rd_field[ADDRESSWIDTH-1:0];
    assign dec_rs1     = rs1_field[ADDRESSWIDTH-1:0];
    assign dec_rs2     = rs2_field[ADDRESSWIDTH-1:0];
    assign dec_imm_raw = instruction[IMMWIDTH-1:0];
    assign dec_imm     = {{(WIDTH-IMMWIDTH){IMM_SIGNED & dec_imm_raw[IMMWIDTH-1]}}, dec_imm_raw};
    assign unused_fields = ^{rd_field, rs1_field, rs2_field};

    // Register file storage
    logic [WIDTH-1:0] rf [REGNUM];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < REGNUM; i++) begin
                rf[i] <= '0;
            end
        end else if (writeE) begin
            for (int unsigned i = 0; i < REGNUM; i++) begin
                if ((32'(writeA) == i) && !(ZERO_REG && (i == 0))) begin
                    rf[i] <= dataToSave;
                end
            end
        end
    end

    // Asynchronous read ports with same-cycle write bypass; r0 forced to zero last
    logic [WIDTH-1:0] rd1_c;
    logic [WIDTH-1:0] rd2_c;

    always_comb begin
        rd1_c = '0;
        rd2_c = '0;
        for (int unsigned i = 0; i < REGNUM; i++) begin
            if (32'(dec_rs1) == i) rd1_c = rf[i];
            if (32'(dec_rs2) == i) rd2_c = rf[i];
        end
        if (writeE && (writeA == dec_rs1)) rd1_c = dataToSave;
        if (writeE && (writeA == dec_rs2)) rd2_c = dataToSave;
        if (ZERO_REG && (dec_rs1 == '0)) rd1_c = '0;
        if (ZERO_REG && (dec_rs2 == '0)) rd2_c = '0;
    end

    logic hazard;

    assign hazard   = inValid & outValid & (opcode == LOAD_OPCODE) &
                      ((dec_rs1 == regDestinationAddress) | (dec_rs2 == regDestinationAddress));
    assign stallOut = hazard | stallIn;

    // ID/EX next-state: flush > stallIn (hold) > hazard bubble > load > bubble
    logic                    nxt_valid;
    logic [OPCODEWIDTH-1:0]  nxt_op;
    logic [ADDRESSWIDTH-1:0] nxt_rd;
    logic [ADDRESSWIDTH-1:0] nxt_r1;
    logic [ADDRESSWIDTH-1:0] nxt_r2;
    logic [WIDTH-1:0]        nxt_d1;
    logic [WIDTH-1:0]        nxt_d2;
    logic [WIDTH-1:0]        nxt_imm;
    logic [WIDTH-1:0]        nxt_pc;
    logic [CNTWIDTH-1:0]     nxt_cnt;

    always_comb begin
        nxt_valid = 1'b0;
        nxt_op    = '0;
        nxt_rd    = '0;
        nxt_r1    = '0;
        nxt_r2    = '0;
        nxt_d1    = '0;
        nxt_d2    = '0;
        nxt_imm   = '0;
        nxt_pc    = '0;
        nxt_cnt   = hazardCount;
        if (!flush) begin
            if (stallIn) begin
                nxt_valid = outValid;
                nxt_op    = opcode;
                nxt_rd    = regDestinationAddress;
                nxt_r1    = r1A;
                nxt_r2    = r2A;
                nxt_d1    = rd1D;
                nxt_d2    = rd2D;
                nxt_imm   = inmediate;
                nxt_pc    = pcOut;
            end else if (hazard) begin
                if (hazardCount != '1) nxt_cnt = hazardCount + CNTWIDTH'(1);
            end else if (inValid) begin
                nxt_valid = 1'b1;
                nxt_op    = dec_op;
                nxt_rd    = dec_rd;
                nxt_r1    = dec_rs1;
                nxt_r2    = dec_rs2;
                nxt_d1    = rd1_c;
                nxt_d2    = rd2_c;
                nxt_imm   = dec_imm;
                nxt_pc    = PC;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outValid              <= 1'b0;
            opcode                <= '0;
            regDestinationAddress <= '0;
            r1A                   <= '0;
            r2A                   <= '0;
            rd1D                  <= '0;
            rd2D                  <= '0;
            inmediate             <= '0;
            pcOut                 <= '0;
            hazardCount           <= '0;
        end else begin
            outValid              <= nxt_valid;
            opcode                <= nxt_op;
            regDestinationAddress <= nxt_rd;
            r1A                   <= nxt_r1;
            r2A                   <= nxt_r2;
            rd1D                  <= nxt_d1;
            rd2D                  <= nxt_d2;
            inmediate             <= nxt_imm;
            pcOut                 <= nxt_pc;
            hazardCount           <= nxt_cnt;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed vector table, random traffic against a reference
// model, and hand sequences for immediate extension, r0 handling and async reset.
module tb_decode_pipe;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic [23:0] instruction;
    logic [31:0] PC;
    logic        writeE;
    logic [2:0]  writeA;
    logic [31:0] dataToSave;
    logic        flush;
    logic        stallIn;

    logic        ov  [2];
    logic [3:0]  op  [2];
    logic [2:0]  rdA [2];
    logic [2:0]  r1A [2];
    logic [2:0]  r2A [2];
    logic [31:0] d1  [2];
    logic [31:0] d2  [2];
    logic [31:0] imm [2];
    logic [31:0] pco [2];
    logic        so  [2];
    logic [15:0] hc  [2];

    // dut0: defaults; dut1: signed immediate and hard-wired r0
    decode_pipe dut0 (
        .clk(clk), .reset(reset), .inValid(inValid), .instruction(instruction), .PC(PC),
        .writeE(writeE), .writeA(writeA), .dataToSave(dataToSave), .flush(flush),
        .stallIn(stallIn), .outValid(ov[0]), .opcode(op[0]), .regDestinationAddress(rdA[0]),
        .r1A(r1A[0]), .r2A(r2A[0]), .rd1D(d1[0]), .rd2D(d2[0]), .inmediate(imm[0]),
        .pcOut(pco[0]), .stallOut(so[0]), .hazardCount(hc[0])
    );

    decode_pipe #(.IMM_SIGNED(1'b1), .ZERO_REG(1'b1)) dut1 (
        .clk(clk), .reset(reset), .inValid(inValid), .instruction(instruction), .PC(PC),
        .writeE(writeE), .writeA(writeA), .dataToSave(dataToSave), .flush(flush),
        .stallIn(stallIn), .outValid(ov[1]), .opcode(op[1]), .regDestinationAddress(rdA[1]),
        .r1A(r1A[1]), .r2A(r2A[1]), .rd1D(d1[1]), .rd2D(d2[1]), .inmediate(imm[1]),
        .pcOut(pco[1]), .stallOut(so[1]), .hazardCount(hc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] pc;
    } idex_t;

    idex_t       mo   [2];
    logic [31:0] mrf  [2][8];
    logic [15:0] mcnt [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            mo[k]   = '0;
            mcnt[k] = '0;
            for (int r = 0; r < 8; r++) mrf[k][r] = '0;
        end
    endtask

    // Register value seen by a reader this cycle (k==1 model has r0 tied to zero)
    function automatic logic [31:0] mread(input int k, input logic [2:0] a);
        if (k == 1 && a == 3'd0) return 32'h0;
        if (writeE && writeA == a) return dataToSave;
        return mrf[k][a];
    endfunction

    function automatic logic mhaz(input int k);
        logic [2:0] s1 = instruction[14:12];
        logic [2:0] s2 = instruction[10:8];
        return inValid && mo[k].valid && mo[k].op == 4'd3 && (s1 == mo[k].rd || s2 == mo[k].rd);
    endfunction

    task automatic medge();
        for (int k = 0; k < 2; k++) begin
            idex_t      nxt;
            logic [7:0] i8 = instruction[7:0];
            nxt = '0;
            if (flush) nxt = '0;
            else if (stallIn) nxt = mo[k];
            else if (mhaz(k)) begin
                if (mcnt[k] != 16'hFFFF) mcnt[k] = mcnt[k] + 16'd1;
            end else if (inValid) begin
                nxt.valid = 1'b1;
                nxt.op    = instruction[23:20];
                nxt.rd    = instruction[18:16];
                nxt.r1    = instruction[14:12];
                nxt.r2    = instruction[10:8];
                nxt.d1    = mread(k, instruction[14:12]);
                nxt.d2    = mread(k, instruction[10:8]);
                nxt.imm   = (k == 1 && i8[7]) ? (32'hFFFFFF00 | 32'(i8)) : 32'(i8);
                nxt.pc    = PC;
            end
            if (writeE && !(k == 1 && writeA == 3'd0)) mrf[k][writeA] = dataToSave;
            mo[k] = nxt;
        end
    endtask

    task automatic cmp_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d.outValid", k), 32'(ov[k]), 32'(mo[k].valid));
            chk($sformatf("d%0d.opcode", k), 32'(op[k]), 32'(mo[k].op));
            chk($sformatf("d%0d.rdAddr", k), 32'(rdA[k]), 32'(mo[k].rd));
            chk($sformatf("d%0d.r1A", k), 32'(r1A[k]), 32'(mo[k].r1));
            chk($sformatf("d%0d.r2A", k), 32'(r2A[k]), 32'(mo[k].r2));
            chk($sformatf("d%0d.rd1D", k), d1[k], mo[k].d1);
            chk($sformatf("d%0d.rd2D", k), d2[k], mo[k].d2);
            chk($sformatf("d%0d.inmediate", k), imm[k], mo[k].imm);
            chk($sformatf("d%0d.pcOut", k), pco[k], mo[k].pc);
            chk($sformatf("d%0d.hazardCount", k), 32'(hc[k]), 32'(mcnt[k]));
        end
    endtask

    // Inputs are set at a negedge; check stall, take the edge, check registers
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("d%0d.stallOut", k), 32'(so[k]), 32'(mhaz(k) | stallIn));
        @(posedge clk);
        medge();
        @(negedge clk);
        cmp_all();
    endtask

    typedef struct {
        logic        iv;
        logic [23:0] ins;
        logic        we;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic        st;
        logic        e_stall;
        logic        e_valid;
        logic [3:0]  e_op;
        logic [2:0]  e_r1;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic [31:0] e_pc;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // iv  ins       we wa  wd         fl st  stall vld op r1 d1         d2     pc         cnt
        tbl[0]  = '{0, 24'h000000, 1, 3'd1, 32'd5,    0, 0, 0, 0, 4'd0, 3'd0, 32'd0,    32'd0, 32'h000, 16'd0};
        tbl[1]  = '{0, 24'h000000, 1, 3'd2, 32'd7,    0, 0, 0, 0, 4'd0, 3'd0, 32'd0,    32'd0, 32'h000, 16'd0};
        tbl[2]  = '{1, 24'h501200, 0, 3'd0, 32'd0,    0, 0, 0, 1, 4'd5, 3'd1, 32'd5,    32'd7, 32'h108, 16'd0};
        tbl[3]  = '{1, 24'h656700, 1, 3'd6, 32'h1234, 0, 0, 0, 1, 4'd6, 3'd6, 32'h1234, 32'd0, 32'h10C, 16'd0};
        tbl[4]  = '{1, 24'h340000, 0, 3'd0, 32'd0,    0, 0, 0, 1, 4'd3, 3'd0, 32'd0,    32'd0, 32'h110, 16'd0};
        tbl[5]  = '{1, 24'h514200, 0, 3'd0, 32'd0,    0, 0, 1, 0, 4'd0, 3'd0, 32'd0,    32'd0, 32'h000, 16'd1};
        tbl[6]  = '{1, 24'h514200, 0, 3'd0, 32'd0,    0, 0, 0, 1, 4'd5, 3'd4, 32'd0,    32'd7, 32'h118, 16'd1};
        tbl[7]  = '{1, 24'h340000, 0, 3'd0, 32'd0,    0, 0, 0, 1, 4'd3, 3'd0, 32'd0,    32'd0, 32'h11C, 16'd1};
        tbl[8]  = '{1, 24'h514200, 0, 3'd0, 32'd0,    1, 1, 1, 0, 4'd0, 3'd0, 32'd0,    32'd0, 32'h000, 16'd1};
        tbl[9]  = '{1, 24'h501200, 0, 3'd0, 32'd0,    0, 0, 0, 1, 4'd5, 3'd1, 32'd5,    32'd7, 32'h124, 16'd1};
        tbl[10] = '{1, 24'h656700, 1, 3'd1, 32'h99,   0, 1, 1, 1, 4'd5, 3'd1, 32'd5,    32'd7, 32'h124, 16'd1};
        tbl[11] = '{1, 24'h656700, 0, 3'd0, 32'd0,    0, 1, 1, 1, 4'd5, 3'd1, 32'd5,    32'd7, 32'h124, 16'd1};
        tbl[12] = '{0, 24'h000000, 0, 3'd0, 32'd0,    0, 1, 1, 1, 4'd5, 3'd1, 32'd5,    32'd7, 32'h124, 16'd1};
        tbl[13] = '{0, 24'h000000, 0, 3'd0, 32'd0,    0, 0, 0, 0, 4'd0, 3'd0, 32'd0,    32'd0, 32'h000, 16'd1};
        tbl[14] = '{1, 24'h501200, 0, 3'd0, 32'd0,    0, 0, 0, 1, 4'd5, 3'd1, 32'h99,   32'd7, 32'h138, 16'd1};

        reset = 1'b0; inValid = 1'b0; instruction = '0; PC = '0; writeE = 1'b0;
        writeA = '0; dataToSave = '0; flush = 1'b0; stallIn = 1'b0;
        mreset();
        repeat (2) @(negedge clk);
        cmp_all();
        reset = 1'b1;

        // Directed table starting from the cleared state
        for (int i = 0; i < 15; i++) begin
            inValid = tbl[i].iv; instruction = tbl[i].ins; PC = 32'h100 + 32'(4 * i);
            writeE = tbl[i].we; writeA = tbl[i].wa; dataToSave = tbl[i].wd;
            flush = tbl[i].fl; stallIn = tbl[i].st;
            #1;
            chk($sformatf("vec%0d.stallOut", i), 32'(so[0]), 32'(tbl[i].e_stall));
            step();
            chk($sformatf("vec%0d.outValid", i), 32'(ov[0]), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d.opcode", i), 32'(op[0]), 32'(tbl[i].e_op));
            chk($sformatf("vec%0d.r1A", i), 32'(r1A[0]), 32'(tbl[i].e_r1));
            chk($sformatf("vec%0d.rd1D", i), d1[0], tbl[i].e_d1);
            chk($sformatf("vec%0d.rd2D", i), d2[0], tbl[i].e_d2);
            chk($sformatf("vec%0d.pcOut", i), pco[0], tbl[i].e_pc);
            chk($sformatf("vec%0d.hazardCount", i), 32'(hc[0]), 32'(tbl[i].e_cnt));
        end

        // Random traffic, loads biased so load-use hazards occur often
        for (int n = 0; n < 400; n++) begin
            logic [3:0] r_op;
            r_op = ($urandom_range(0, 2) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
            inValid     = ($urandom_range(0, 9) < 8);
            instruction = {r_op, 20'($urandom)};
            PC          = $urandom;
            writeE      = 1'($urandom_range(0, 1));
            writeA      = 3'($urandom_range(0, 7));
            dataToSave  = $urandom;
            flush       = ($urandom_range(0, 11) == 0);
            stallIn     = ($urandom_range(0, 5) == 0);
            step();
        end

        // Immediate extension and r0 behaviour
        flush = 1'b0; stallIn = 1'b0; writeE = 1'b0; inValid = 1'b1;
        instruction = 24'h5123F0; PC = 32'h200;
        step();
        chk("imm_zero_ext", imm[0], 32'h000000F0);
        chk("imm_sign_ext", imm[1], 32'hFFFFFFF0);
        writeE = 1'b1; writeA = 3'd0; dataToSave = 32'd9; instruction = 24'h500000;
        step();
        chk("r0_bypass_zr", d1[1], 32'd0);
        chk("r0_bypass_plain", d1[0], 32'd9);
        writeE = 1'b0;
        step();
        chk("r0_read_zr", d1[1], 32'd0);
        chk("r0_read_plain", d1[0], 32'd9);

        // Async reset asserted between edges while a load-use hazard is pending
        instruction = 24'h340000;
        step();
        instruction = 24'h514200;
        #1;
        chk("pre_reset_stall", 32'(so[0]), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_outValid", 32'(ov[0]), 32'd0);
        chk("rst_opcode", 32'(op[0]), 32'd0);
        chk("rst_rdAddr", 32'(rdA[0]), 32'd0);
        chk("rst_rd1D", d1[0], 32'd0);
        chk("rst_pcOut", pco[0], 32'd0);
        chk("rst_hazardCount", 32'(hc[0]), 32'd0);
        chk("rst_stallOut", 32'(so[0]), 32'd0);
        mreset();
        cmp_all();
        @(negedge clk);
        reset = 1'b1;
        instruction = 24'h501200;
        step();
        chk("post_reset_r1", d1[0], 32'd0);
        chk("post_reset_valid", 32'(ov[0]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameters (name, default, meaning):
- WIDTH, 32, data width
- REGNUM, 8, register count
- ADDRESSWIDTH, 3, register address width
- OPCODEWIDTH, 4, opcode width
- INSTRUCTIONWIDTH, 24, instruction width
- FIELDWIDTH, 4, register field width in instruction, at least ADDRESSWIDTH
- IMM_SIGNED, 0, 1 = sign-extend immediate, 0 = zero-extend
- ZERO_REG, 0, 1 = register 0 reads 0 and ignores writes
- LOAD_OPCODE, 4'b0011, opcode treated as a load for hazard detection
- CNTWIDTH, 16, hazard counter width

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state is updated on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- inValid, in, 1, instruction/PC are valid.
- instruction, in, INSTRUCTIONWIDTH, fetched instruction.
- PC, in, WIDTH, instruction address.
- writeE, in, 1, register-file write enable from writeback.
- writeA, in, ADDRESSWIDTH, write address.
- dataToSave, in, WIDTH, write data.
- flush, in, 1, kill the instruction entering EX.
- stallIn, in, 1, downstream hold.
- outValid, out, 1, ID/EX holds a real instruction.
- opcode, out, OPCODEWIDTH, registered opcode.
- regDestinationAddress, r1A, r2A, out, ADDRESSWIDTH each, registered rd/rs1/rs2.
- rd1D, rd2D, out, WIDTH each, registered operand data.
- inmediate, out, WIDTH, registered extended immediate.
- pcOut, out, WIDTH, registered PC.
- stallOut, out, 1, combinational; fetch shall hold PC and instruction.
- hazardCount, out, CNTWIDTH, number of load-use bubbles inserted.

Function
REQ-003 Instruction fields, MSB first: opcode[OPCODEWIDTH], rd[FIELDWIDTH], rs1[FIELDWIDTH], rs2[FIELDWIDTH], imm = remaining LSBs. Addresses use the low ADDRESSWIDTH bits of each field.
REQ-004 Immediate is extended to WIDTH: sign-extended when IMM_SIGNED=1, zero-extended when IMM_SIGNED=0.
REQ-005 Register file write: REGNUM x WIDTH, written on the rising edge when writeE=1. Writes to addresses >= REGNUM are ignored.
REQ-006 Register file read: asynchronous. When writeE=1 and writeA equals the read address, the read returns dataToSave (write-through bypass).
REQ-007 ZERO_REG=1: address 0 always reads 0, including through the bypass path.
REQ-008 hazard = inValid & outValid & (opcode==LOAD_OPCODE) & ((rs1==regDestinationAddress) | (rs2==regDestinationAddress)). Both sources are always compared.
REQ-009 stallOut = hazard | stallIn.
REQ-010 ID/EX update priority on each rising edge:
- 1. flush: load a bubble.
- 2. stallIn: hold all outputs.
- 3. hazard: load a bubble.
- 4. inValid=1: load the decoded fields.
- 5. otherwise: load a bubble.
REQ-011 A bubble sets outValid=0 and sets every other registered output to 0.
REQ-012 Decode-to-output latency is 1 cycle. While stallIn holds, rd1D and rd2D are not refreshed by later writes.
REQ-013 hazardCount increments by 1 on each edge where a hazard bubble is loaded (priority 3 taken). It saturates at all-ones.
REQ-014 flush and stallIn together: flush wins. A simultaneous hazard does not increment hazardCount.

Reset
REQ-015 reset=0 immediately clears all ID/EX outputs, outValid, hazardCount and every register-file entry to 0, independent of clk.
REQ-016 Deasserting reset mid-stall or mid-hazard resumes from the cleared state. The first edge after release follows REQ-010.

Verification
REQ-017 Reg r1=5 and r2=7 preloaded; inValid=1, instruction=24'h501200 -> one edge later: opcode=5, regDestinationAddress=0, r1A=1, r2A=2, rd1D=5, rd2D=7, outValid=1.
REQ-018 Bypass: writeE=1, writeA=6, dataToSave=32'h1234 in the same cycle as instruction=24'h656700 -> rd1D=32'h1234 after the edge.
REQ-019 Load-use: load 24'h340000 (rd=4), then 24'h514200 -> stallOut=1 for 1 cycle, one bubble (outValid=0), hazardCount=1; the next edge loads opcode=5, r1A=4.
REQ-020 Priority: flush=1 and stallIn=1 with a valid instruction -> outValid=0 and hazardCount unchanged. stallIn alone held for 3 cycles -> outputs unchanged.
REQ-021 IMM_SIGNED=1, imm=8'hF0 -> inmediate=32'hFFFFFFF0. IMM_SIGNED=0 -> 32'h000000F0. ZERO_REG=1 with a write of 9 to r0 -> r0 still reads 0.
REQ-022 Assert reset=0 between clock edges during a hazard -> all outputs are 0 immediately, hazardCount=0, r1 reads 0.
